// File: rtl/binary_game_core.sv
// rtl/binary_game_core.sv - guess-the-secret game core with LFSR target, timeout and verdict hold
module binary_game_core #(
    parameter int              WIDTH          = 12,
    parameter int              ROUNDS         = 8,
    parameter int              TIMEOUT_CYCLES = 1000000000,
    parameter int              RESULT_HOLD    = 100000000,
    parameter logic [WIDTH-1:0] SEED          = WIDTH'(64),
    parameter logic [WIDTH-1:0] LFSR_TAPS     = WIDTH'(12'h829)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] sw,
    input  logic             btn_submit,
    input  logic             btn_start,
    output logic [WIDTH-1:0] secret,
    output logic [7:0]       score,
    output logic [7:0]       round_idx,
    output logic             led_correct,
    output logic             led_wrong,
    output logic             timed_out,
    output logic             playing,
    output logic             game_over
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int HW = $clog2(RESULT_HOLD + 1);
    localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(RESULT_HOLD - 1);
    localparam logic [7:0]    LAST_ROUND = 8'(ROUNDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_RESULT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [TW-1:0]   timer;
    logic [HW-1:0]   hold;
    logic [WIDTH-1:0] lfsr;
    logic            verdict_correct, verdict_wrong, verdict_timeout;

    logic            sub_s1, sub_s2, sub_prev, sub_arm, sub_pulse;
    logic            sta_s1, sta_s2, sta_prev, sta_arm, sta_pulse;
    logic [1:0]      settle;
    logic            guess_hit;
    logic [WIDTH-1:0] lfsr_step;

    assign guess_hit = (sw == lfsr);
    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    assign secret    = lfsr;

    // Synchronise buttons and register a one-cycle rising-edge pulse; a button
    // only arms once it has been seen released after the synchroniser settles,
    // so a press held through reset release is ignored until re-pressed.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sub_s1    <= 1'b0;
            sub_s2    <= 1'b0;
            sub_prev  <= 1'b0;
            sub_arm   <= 1'b0;
            sub_pulse <= 1'b0;
            sta_s1    <= 1'b0;
            sta_s2    <= 1'b0;
            sta_prev  <= 1'b0;
            sta_arm   <= 1'b0;
            sta_pulse <= 1'b0;
            settle    <= 2'b00;
        end else begin
            settle    <= {settle[0], 1'b1};
            sub_s1    <= btn_submit;
            sub_s2    <= sub_s1;
            sub_prev  <= sub_s2;
            sub_arm   <= sub_arm | (settle[1] & ~sub_s2);
            sub_pulse <= sub_s2 & ~sub_prev & sub_arm;
            sta_s1    <= btn_start;
            sta_s2    <= sta_s1;
            sta_prev  <= sta_s2;
            sta_arm   <= sta_arm | (settle[1] & ~sta_s2);
            sta_pulse <= sta_s2 & ~sta_prev & sta_arm;
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decision; a submit pulse takes priority over timer expiry
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (sta_pulse) state_nxt = S_PLAY;
            S_PLAY:   if (sub_pulse || timer == '0) state_nxt = S_RESULT;
            S_RESULT: if (hold == '0) state_nxt = (round_idx == LAST_ROUND) ? S_DONE : S_PLAY;
            S_DONE:   if (sta_pulse) state_nxt = S_PLAY;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Game datapath: score, round, timers, LFSR target and verdict flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            score           <= 8'd0;
            round_idx       <= 8'd0;
            timer           <= TIMER_MAX;
            hold            <= HOLD_MAX;
            lfsr            <= SEED;
            verdict_correct <= 1'b0;
            verdict_wrong   <= 1'b0;
            verdict_timeout <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (sta_pulse) begin
                        score     <= 8'd0;
                        round_idx <= 8'd0;
                        timer     <= TIMER_MAX;
                    end
                end
                S_PLAY: begin
                    if (sub_pulse) begin
                        verdict_correct <= guess_hit;
                        verdict_wrong   <= ~guess_hit;
                        verdict_timeout <= 1'b0;
                        hold            <= HOLD_MAX;
                        if (guess_hit && score != 8'hFF) score <= score + 8'd1;
                    end else if (timer == '0) begin
                        verdict_correct <= 1'b0;
                        verdict_wrong   <= 1'b1;
                        verdict_timeout <= 1'b1;
                        hold            <= HOLD_MAX;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_RESULT: begin
                    if (hold == '0) begin
                        verdict_correct <= 1'b0;
                        verdict_wrong   <= 1'b0;
                        verdict_timeout <= 1'b0;
                        if (round_idx != LAST_ROUND) begin
                            round_idx <= round_idx + 8'd1;
                            lfsr      <= lfsr_step;
                            timer     <= TIMER_MAX;
                        end
                    end else begin
                        hold <= hold - HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Status outputs; verdict LEDs are gated so they only show during RESULT
    always_comb begin
        playing     = (state == S_PLAY);
        game_over   = (state == S_DONE);
        led_correct = verdict_correct & (state == S_RESULT);
        led_wrong   = verdict_wrong   & (state == S_RESULT);
        timed_out   = verdict_timeout & (state == S_RESULT);
    end

endmodule

// File: doc/binary_game_core.md
BINARY_GAME_CORE -- requirements
Module: binary_game_core

Interface
REQ-001 Parameter WIDTH, default 12: guess/secret width in bits.
REQ-002 Parameter ROUNDS, default 8: rounds per game, range 1..255.
REQ-003 Parameter TIMEOUT_CYCLES, default 1000000000: cycles allowed per guess, ≥2.
REQ-004 Parameter RESULT_HOLD, default 100000000: cycles the verdict is shown, ≥1.
REQ-005 Parameter SEED, default 64: LFSR reset value, nonzero.
REQ-006 Parameter LFSR_TAPS, default 12'h829: Galois tap mask, WIDTH bits.
REQ-007 clk  input  1  system clock, 100 MHz.
REQ-008 reset  input  1  asynchronous, active-low reset.
REQ-009 sw  input  WIDTH  player guess, asynchronous, sampled only at submit.
REQ-010 btn_submit  input  1  debounced submit button, asynchronous to clk.
REQ-011 btn_start  input  1  debounced start button, asynchronous to clk.
REQ-012 secret  output  WIDTH  current target value, for the display driver.
REQ-013 score  output  8  correct guesses in the current game.
REQ-014 round_idx  output  8  zero-based current round.
REQ-015 led_correct  output  1  high in RESULT when the last guess matched.
REQ-016 led_wrong  output  1  high in RESULT when the last guess missed or timed out.
REQ-017 timed_out  output  1  high in RESULT when the verdict came from timeout.
REQ-018 playing  output  1  high in PLAY.
REQ-019 game_over  output  1  high in DONE.

Function
REQ-020 btn_submit and btn_start each pass a 2-flop synchroniser; a rising edge is sync2=1 with previous sync2=0, giving a one-cycle pulse.
REQ-021 FSM states: IDLE, PLAY, RESULT, DONE; encoding free.
REQ-022 IDLE: start pulse -> PLAY, score=0, round_idx=0, timer=TIMEOUT_CYCLES-1; submit ignored.
REQ-023 PLAY: submit pulse -> RESULT; sw captured that cycle; led_correct=(sw==secret), led_wrong=!match, score+1 on match.
REQ-024 Latency: btn_submit high at clk edge k, stable -> led_correct/led_wrong high after edge k+3.
REQ-025 PLAY: timer decrements each cycle; timer==0 with no submit pulse -> RESULT with led_wrong=1, timed_out=1, no score change.
REQ-026 Submit pulse in the same cycle as timer==0: submit wins, timed_out=0.
REQ-027 RESULT lasts exactly RESULT_HOLD cycles; submit and start ignored.
REQ-028 RESULT exit: if round_idx==ROUNDS-1 -> DONE, round_idx unchanged; else round_idx+1, LFSR advanced once, timer reloaded, -> PLAY.
REQ-029 LFSR step: lsb=1 -> (x>>1)^LFSR_TAPS; lsb=0 -> x>>1; secret equals LFSR state; never zero.
REQ-030 LFSR advances only at REQ-028 round transitions and is not reseeded at a new game.
REQ-031 DONE: score and round_idx held; start pulse -> PLAY as in REQ-022.
REQ-032 led_correct, led_wrong, timed_out are 0 outside RESULT.
REQ-033 score saturates at 255; width rules: round_idx and score are zero-extended to 8 bits.

Reset
REQ-034 reset low asynchronously forces IDLE, secret=SEED, score=0, round_idx=0, all flags 0, synchronisers 0, timer=TIMEOUT_CYCLES-1.
REQ-035 Reset asserted mid-game aborts immediately; no verdict is produced for a pending submit; release is synchronous to clk.
REQ-036 A button already held at reset release produces no pulse until released and pressed again.

Verification (ROUNDS=2, TIMEOUT_CYCLES=100, RESULT_HOLD=4, other parameters default)
REQ-037 reset low 5 cycles, release -> IDLE, secret=0x040, all outputs 0; start -> playing=1 after 3 edges.
REQ-038 Wrong guess: sw=8, submit -> led_wrong=1 for 4 cycles, score=0; then secret=0x020, round_idx=1.
REQ-039 Correct guess: sw=0x020, submit in round 1 -> led_correct=1, score=1; after 4 cycles game_over=1, round_idx=1.
REQ-040 Timeout: start, no submit for 100 cycles -> led_wrong=1, timed_out=1, score unchanged.
REQ-041 Submit pulse coincident with timer==0 and sw==secret -> led_correct=1, timed_out=0.
REQ-042 reset pulsed low during RESULT -> IDLE, no LEDs, secret=0x040; held btn_start does not start a game until re-pressed.
